// File: rtl/cop_req_initiator.sv
// CPU-side coprocessor request initiator: queues core instructions toward the coprocessor,
// pairs in-order responses with destination tags, and limits how many responses can be outstanding.
module cop_req_initiator #(
    parameter int unsigned COP_INST_WIDTH = 32,
    parameter int unsigned COP_REG_WIDTH  = 64,
    parameter int unsigned REQ_DEPTH      = 4,
    parameter int unsigned MAX_OUTST      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      core_req_vld_i,
    output logic                      core_req_rdy_o,
    input  logic [COP_INST_WIDTH-1:0] core_req_insn_i,
    input  logic [COP_REG_WIDTH-1:0]  core_req_rs1_i,
    input  logic [COP_REG_WIDTH-1:0]  core_req_rs2_i,
    input  logic [COP_REG_WIDTH-1:0]  core_req_rs3_i,
    input  logic [4:0]                core_req_rd_i,
    input  logic                      core_req_xd_i,
    output logic                      cpu_tpu_req_vld_o,
    input  logic                      cpu_tpu_req_rdy_i,
    output logic [COP_INST_WIDTH-1:0] cpu_tpu_req_insn_o,
    output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs1_data_o,
    output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs2_data_o,
    output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs3_data_o,
    input  logic                      cpu_tpu_resp_vld_i,
    output logic                      cpu_tpu_resp_rdy_o,
    input  logic [COP_REG_WIDTH-1:0]  cpu_tpu_resp_data_i,
    output logic                      wb_vld_o,
    input  logic                      wb_rdy_i,
    output logic [4:0]                wb_rd_o,
    output logic [COP_REG_WIDTH-1:0]  wb_data_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int unsigned RD_W = 5;
    localparam int unsigned RP_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned RC_W = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned TP_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned TC_W = $clog2(MAX_OUTST) + 1;

    typedef struct packed {
        logic [COP_INST_WIDTH-1:0] insn;
        logic [COP_REG_WIDTH-1:0]  rs1;
        logic [COP_REG_WIDTH-1:0]  rs2;
        logic [COP_REG_WIDTH-1:0]  rs3;
        logic [RD_W-1:0]           rd;
        logic                      xd;
    } req_entry_t;

    req_entry_t         req_mem_q [REQ_DEPTH];
    logic [RP_W-1:0]    req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [RC_W-1:0]    req_cnt_q, req_cnt_d;
    logic [RD_W-1:0]    tag_mem_q [MAX_OUTST];
    logic [TP_W-1:0]    tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TC_W-1:0]    tag_cnt_q, tag_cnt_d;
    logic [TC_W-1:0]    inflight_q, inflight_d;
    logic               wb_vld_q, wb_vld_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic [COP_REG_WIDTH-1:0] wb_data_q, wb_data_d;
    logic               err_q, err_d;

    logic       fifo_empty, fifo_full, enq, deq, tag_push, tag_pop, resp_hs, wb_hs;
    req_entry_t head;
    req_entry_t new_entry;

    assign head       = req_mem_q[req_rd_q];
    assign fifo_empty = (req_cnt_q == '0);
    assign fifo_full  = (req_cnt_q == RC_W'(REQ_DEPTH));

    assign core_req_rdy_o     = !fifo_full && (inflight_q < TC_W'(MAX_OUTST));
    assign cpu_tpu_req_vld_o  = !fifo_empty;
    assign cpu_tpu_resp_rdy_o = !wb_vld_q || wb_rdy_i;

    assign enq      = core_req_vld_i && core_req_rdy_o;
    assign deq      = cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i;
    assign resp_hs  = cpu_tpu_resp_vld_i && cpu_tpu_resp_rdy_o;
    assign wb_hs    = wb_vld_q && wb_rdy_i;
    assign tag_push = deq && head.xd;
    // Pop only uses registered occupancy: a same-cycle push never satisfies a response.
    assign tag_pop  = resp_hs && (tag_cnt_q != '0);

    assign new_entry = '{insn: core_req_insn_i, rs1: core_req_rs1_i, rs2: core_req_rs2_i,
                         rs3: core_req_rs3_i, rd: core_req_rd_i, xd: core_req_xd_i};

    assign cpu_tpu_req_insn_o     = head.insn;
    assign cpu_tpu_req_rs1_data_o = head.rs1;
    assign cpu_tpu_req_rs2_data_o = head.rs2;
    assign cpu_tpu_req_rs3_data_o = head.rs3;
    assign wb_vld_o  = wb_vld_q;
    assign wb_rd_o   = wb_rd_q;
    assign wb_data_o = wb_data_q;
    assign err_o     = err_q;
    assign busy_o    = !fifo_empty || (inflight_q != '0);

    // Next-state for FIFO pointers, credits and writeback register.
    always_comb begin
        req_wr_d   = req_wr_q;
        req_rd_d   = req_rd_q;
        req_cnt_d  = req_cnt_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_cnt_d  = tag_cnt_q;
        inflight_d = inflight_q;
        wb_vld_d   = wb_vld_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;

        if (enq) req_wr_d = (req_wr_q == RP_W'(REQ_DEPTH - 1)) ? '0 : req_wr_q + RP_W'(1);
        if (deq) req_rd_d = (req_rd_q == RP_W'(REQ_DEPTH - 1)) ? '0 : req_rd_q + RP_W'(1);
        if (enq && !deq)      req_cnt_d = req_cnt_q + RC_W'(1);
        else if (!enq && deq) req_cnt_d = req_cnt_q - RC_W'(1);

        if (tag_push) tag_wr_d = (tag_wr_q == TP_W'(MAX_OUTST - 1)) ? '0 : tag_wr_q + TP_W'(1);
        if (tag_pop)  tag_rd_d = (tag_rd_q == TP_W'(MAX_OUTST - 1)) ? '0 : tag_rd_q + TP_W'(1);
        if (tag_push && !tag_pop)      tag_cnt_d = tag_cnt_q + TC_W'(1);
        else if (!tag_push && tag_pop) tag_cnt_d = tag_cnt_q - TC_W'(1);

        if ((enq && core_req_xd_i) && !wb_hs)      inflight_d = inflight_q + TC_W'(1);
        else if (!(enq && core_req_xd_i) && wb_hs) inflight_d = inflight_q - TC_W'(1);

        if (wb_hs) wb_vld_d = 1'b0;
        if (tag_pop) begin
            wb_vld_d  = 1'b1;
            wb_rd_d   = tag_mem_q[tag_rd_q];
            wb_data_d = cpu_tpu_resp_data_i;
        end
        if (resp_hs && (tag_cnt_q == '0)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_q   <= '0;
            req_rd_q   <= '0;
            req_cnt_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            inflight_q <= '0;
            wb_vld_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            req_wr_q   <= req_wr_d;
            req_rd_q   <= req_rd_d;
            req_cnt_q  <= req_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            inflight_q <= inflight_d;
            wb_vld_q   <= wb_vld_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    // Payload storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq)      req_mem_q[req_wr_q] <= new_entry;
        if (tag_push) tag_mem_q[tag_wr_q] <= head.rd;
    end

endmodule

// File: tb/tb_cop_req_initiator.sv
// Scoreboard bench for cop_req_initiator: directed stimulus pushes expected requests and
// writebacks into queues; negedge monitors pop and compare on every DUT handshake.
module tb_cop_req_initiator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_vld_i, core_req_rdy_o, core_req_xd_i;
    logic [31:0] core_req_insn_i;
    logic [63:0] core_req_rs1_i, core_req_rs2_i, core_req_rs3_i;
    logic [4:0]  core_req_rd_i;
    logic        cpu_tpu_req_vld_o, cpu_tpu_req_rdy_i;
    logic [31:0] cpu_tpu_req_insn_o;
    logic [63:0] cpu_tpu_req_rs1_data_o, cpu_tpu_req_rs2_data_o, cpu_tpu_req_rs3_data_o;
    logic        cpu_tpu_resp_vld_i, cpu_tpu_resp_rdy_o;
    logic [63:0] cpu_tpu_resp_data_i;
    logic        wb_vld_o, wb_rdy_i;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic        busy_o, err_o;

    always #5 clk = ~clk;

    cop_req_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_vld_i(core_req_vld_i), .core_req_rdy_o(core_req_rdy_o),
        .core_req_insn_i(core_req_insn_i), .core_req_rs1_i(core_req_rs1_i),
        .core_req_rs2_i(core_req_rs2_i), .core_req_rs3_i(core_req_rs3_i),
        .core_req_rd_i(core_req_rd_i), .core_req_xd_i(core_req_xd_i),
        .cpu_tpu_req_vld_o(cpu_tpu_req_vld_o), .cpu_tpu_req_rdy_i(cpu_tpu_req_rdy_i),
        .cpu_tpu_req_insn_o(cpu_tpu_req_insn_o),
        .cpu_tpu_req_rs1_data_o(cpu_tpu_req_rs1_data_o),
        .cpu_tpu_req_rs2_data_o(cpu_tpu_req_rs2_data_o),
        .cpu_tpu_req_rs3_data_o(cpu_tpu_req_rs3_data_o),
        .cpu_tpu_resp_vld_i(cpu_tpu_resp_vld_i), .cpu_tpu_resp_rdy_o(cpu_tpu_resp_rdy_o),
        .cpu_tpu_resp_data_i(cpu_tpu_resp_data_i),
        .wb_vld_o(wb_vld_o), .wb_rdy_i(wb_rdy_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1, rs2, rs3;
    } req_exp_t;
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    req_exp_t   req_q[$];
    wb_exp_t    wb_q[$];
    logic [4:0] tag_model[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic enq(input logic [31:0] insn, input logic [63:0] rs1, input logic [4:0] rd,
                       input logic xd);
        int n;
        req_exp_t e;
        core_req_vld_i  = 1'b1;
        core_req_insn_i = insn;
        core_req_rs1_i  = rs1;
        core_req_rs2_i  = rs1 + 64'h100;
        core_req_rs3_i  = rs1 + 64'h200;
        core_req_rd_i   = rd;
        core_req_xd_i   = xd;
        n = 0;
        forever begin
            @(negedge clk);
            if (core_req_rdy_o) break;
            if (++n > 50) begin fail("enq_timeout"); break; end
        end
        e.insn = insn; e.rs1 = rs1; e.rs2 = rs1 + 64'h100; e.rs3 = rs1 + 64'h200;
        req_q.push_back(e);
        if (xd) tag_model.push_back(rd);
        @(posedge clk); #1;
        core_req_vld_i = 1'b0;
    endtask

    task automatic resp(input logic [63:0] data);
        int n;
        wb_exp_t w;
        cpu_tpu_resp_vld_i  = 1'b1;
        cpu_tpu_resp_data_i = data;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_tpu_resp_rdy_o) break;
            if (++n > 50) begin fail("resp_timeout"); break; end
        end
        if (tag_model.size() != 0) begin
            w.rd = tag_model.pop_front(); w.data = data;
            wb_q.push_back(w);
        end
        @(posedge clk); #1;
        cpu_tpu_resp_vld_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request-channel monitor.
    always @(negedge clk) begin
        if (rst_n && cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i) begin
            if (req_q.size() == 0) fail("req_unexpected");
            else begin
                req_exp_t e;
                e = req_q.pop_front();
                chk("req_insn", 64'(cpu_tpu_req_insn_o), 64'(e.insn));
                chk("req_rs1", cpu_tpu_req_rs1_data_o, e.rs1);
                chk("req_rs2", cpu_tpu_req_rs2_data_o, e.rs2);
                chk("req_rs3", cpu_tpu_req_rs3_data_o, e.rs3);
            end
        end
    end

    // Writeback monitor, including hold-while-stalled check.
    logic        stall_prev = 1'b0;
    logic [4:0]  held_rd;
    logic [63:0] held_data;
    always @(negedge clk) begin
        if (!rst_n) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                chk("wb_hold_vld", 64'(wb_vld_o), 64'd1);
                chk("wb_hold_rd", 64'(wb_rd_o), 64'(held_rd));
                chk("wb_hold_data", wb_data_o, held_data);
            end
            if (wb_vld_o && wb_rdy_i) begin
                if (wb_q.size() == 0) fail("wb_unexpected");
                else begin
                    wb_exp_t w;
                    w = wb_q.pop_front();
                    chk("wb_rd", 64'(wb_rd_o), 64'(w.rd));
                    chk("wb_data", wb_data_o, w.data);
                end
            end
            stall_prev = wb_vld_o && !wb_rdy_i;
            held_rd    = wb_rd_o;
            held_data  = wb_data_o;
        end
    end

    initial begin
        rst_n = 1'b0;
        core_req_vld_i = 1'b0; core_req_insn_i = '0; core_req_rs1_i = '0;
        core_req_rs2_i = '0; core_req_rs3_i = '0; core_req_rd_i = '0; core_req_xd_i = 1'b0;
        cpu_tpu_req_rdy_i = 1'b1; cpu_tpu_resp_vld_i = 1'b0; cpu_tpu_resp_data_i = '0;
        wb_rdy_i = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        chk("rst_core_rdy", 64'(core_req_rdy_o), 64'd1);
        chk("rst_req_vld", 64'(cpu_tpu_req_vld_o), 64'd0);
        chk("rst_resp_rdy", 64'(cpu_tpu_resp_rdy_o), 64'd1);
        chk("rst_wb_vld", 64'(wb_vld_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // Single round trip.
        enq(32'hC0DE_0001, 64'h11, 5'd5, 1'b1);
        chk("t1_req_vld", 64'(cpu_tpu_req_vld_o), 64'd1);
        chk("t1_req_rs1", cpu_tpu_req_rs1_data_o, 64'h11);
        idle(2);
        resp(64'hABCD);
        chk("t1_wb_vld", 64'(wb_vld_o), 64'd1);
        chk("t1_wb_rd", 64'(wb_rd_o), 64'd5);
        chk("t1_wb_data", wb_data_o, 64'hABCD);
        idle(1);
        chk("t1_busy", 64'(busy_o), 64'd0);

        // Fill request FIFO under backpressure, then drain back-to-back.
        cpu_tpu_req_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) enq(32'hA000_0000 + 32'(i), 64'h20 + 64'(i), 5'd0, 1'b0);
        chk("t2_full_rdy", 64'(core_req_rdy_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_vld", 64'(cpu_tpu_req_vld_o), 64'd1);
            chk("t2_hold_insn", 64'(cpu_tpu_req_insn_o), 64'hA000_0000);
            chk("t2_hold_rs1", cpu_tpu_req_rs1_data_o, 64'h20);
        end
        @(posedge clk); #1;
        cpu_tpu_req_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_stream_vld", 64'(cpu_tpu_req_vld_o), 64'd1);
        end
        @(negedge clk);
        chk("t2_drained", 64'(cpu_tpu_req_vld_o), 64'd0);
        idle(1);

        // Credit limit.
        for (int i = 0; i < 4; i++) enq(32'hB000_0000 + 32'(i), 64'h40 + 64'(i), 5'(10 + i), 1'b1);
        chk("t3_credit_rdy", 64'(core_req_rdy_o), 64'd0);
        chk("t3_busy", 64'(busy_o), 64'd1);
        idle(2);
        wb_rdy_i = 1'b0;
        resp(64'h100);
        idle(1);
        chk("t3_stall_rdy", 64'(core_req_rdy_o), 64'd0);
        wb_rdy_i = 1'b1;
        idle(1);
        chk("t3_credit_back", 64'(core_req_rdy_o), 64'd1);
        for (int i = 1; i < 4; i++) resp(64'h100 + 64'(i));
        idle(2);

        // Writeback stall blocks responses.
        enq(32'hD000_0000, 64'h60, 5'd20, 1'b1);
        enq(32'hD000_0001, 64'h61, 5'd21, 1'b1);
        idle(2);
        wb_rdy_i = 1'b0;
        resp(64'h200);
        cpu_tpu_resp_vld_i = 1'b1;
        cpu_tpu_resp_data_i = 64'h201;
        @(negedge clk);
        chk("t4_resp_rdy", 64'(cpu_tpu_resp_rdy_o), 64'd0);
        chk("t4_held_data", wb_data_o, 64'h200);
        @(posedge clk); #1;
        wb_rdy_i = 1'b1;
        @(negedge clk);
        chk("t4_resp_rdy_release", 64'(cpu_tpu_resp_rdy_o), 64'd1);
        begin
            wb_exp_t w;
            w.rd = tag_model.pop_front(); w.data = 64'h201;
            wb_q.push_back(w);
        end
        @(posedge clk); #1;
        cpu_tpu_resp_vld_i = 1'b0;
        chk("t4_new_vld", 64'(wb_vld_o), 64'd1);
        chk("t4_new_rd", 64'(wb_rd_o), 64'd21);
        chk("t4_new_data", wb_data_o, 64'h201);
        idle(2);

        // Mixed xd; only xd=1 produce writebacks, in order.
        enq(32'hE000_0000, 64'h70, 5'd1, 1'b1);
        enq(32'hE000_0001, 64'h71, 5'd7, 1'b0);
        enq(32'hE000_0002, 64'h72, 5'd2, 1'b1);
        enq(32'hE000_0003, 64'h73, 5'd8, 1'b0);
        enq(32'hE000_0004, 64'h74, 5'd3, 1'b1);
        idle(2);
        for (int i = 1; i <= 3; i++) resp(64'h300 + 64'(i));
        idle(2);
        chk("t5_busy", 64'(busy_o), 64'd0);

        // Orphan response flags sticky error.
        resp(64'hDEAD);
        chk("t6_err", 64'(err_o), 64'd1);
        chk("t6_no_wb", 64'(wb_vld_o), 64'd0);
        idle(3);
        chk("t6_err_sticky", 64'(err_o), 64'd1);

        // Reset mid-traffic.
        cpu_tpu_req_rdy_i = 1'b0;
        enq(32'hF000_0000, 64'h80, 5'd4, 1'b1);
        enq(32'hF000_0001, 64'h81, 5'd6, 1'b1);
        chk("t6_pre_busy", 64'(busy_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        req_q.delete();
        tag_model.delete();
        chk("t6_rst_core_rdy", 64'(core_req_rdy_o), 64'd1);
        chk("t6_rst_req_vld", 64'(cpu_tpu_req_vld_o), 64'd0);
        chk("t6_rst_wb_vld", 64'(wb_vld_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_err", 64'(err_o), 64'd0);
        cpu_tpu_req_rdy_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Traffic resumes cleanly after reset.
        enq(32'h1234_5678, 64'h90, 5'd9, 1'b1);
        idle(2);
        resp(64'h9999);
        idle(2);
        chk("end_err", 64'(err_o), 64'd0);
        chk("end_req_q", 64'(req_q.size()), 64'd0);
        chk("end_wb_q", 64'(wb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
